// File: rtl/systolic_load_ctrl_if.sv
// Handshake bundle between the load sequencer, row memory, transpose FIFOs and command logic.
interface systolic_load_ctrl_if #(
    parameter int unsigned ROW_W = 3
) ();
    logic             start;
    logic             abort;
    logic             mem_rvalid;
    logic             mem_rd_en;
    logic [ROW_W-1:0] mem_addr;
    logic             fifo_wr;
    logic [ROW_W-1:0] fifo_row;
    logic             fifo_en;
    logic             mac_clr;
    logic             busy;
    logic             done;

    modport master (
        input  start, abort, mem_rvalid,
        output mem_rd_en, mem_addr, fifo_wr, fifo_row, fifo_en, mac_clr, busy, done
    );

    modport slave (
        output start, abort, mem_rvalid,
        input  mem_rd_en, mem_addr, fifo_wr, fifo_row, fifo_en, mac_clr, busy, done
    );
endinterface

// File: rtl/systolic_load_ctrl.sv
// Sequences one matrix-multiply pass: clear accumulators, load DEPTH rows into
// the transpose FIFOs, then shift long enough to skew and drain every lane.
module systolic_load_ctrl #(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned ROW_W     = $clog2(DEPTH),
    parameter int unsigned SHIFT_LEN = 3 * DEPTH - 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    systolic_load_ctrl_if.master bus
);
    localparam int unsigned SC_W = $clog2(SHIFT_LEN);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        LOAD_REQ,
        LOAD_WAIT,
        SHIFT,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [SC_W-1:0]  sc_q, sc_d;
    logic             row_last;
    logic             sc_last;

    assign row_last = (row_q == ROW_W'(DEPTH - 1));
    assign sc_last  = (sc_q == SC_W'(SHIFT_LEN - 1));

    // State and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            row_q   <= '0;
            sc_q    <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            sc_q    <= sc_d;
        end
    end

    // Next state, counters and Moore decode; fifo_wr is the one input-dependent output.
    always_comb begin
        state_d       = state_q;
        row_d         = row_q;
        sc_d          = sc_q;
        bus.mem_rd_en = 1'b0;
        bus.mac_clr   = 1'b0;
        bus.fifo_en   = 1'b0;
        bus.done      = 1'b0;
        bus.busy      = (state_q != IDLE);
        bus.fifo_wr   = (state_q == LOAD_WAIT) && bus.mem_rvalid && !bus.abort;
        bus.mem_addr  = row_q;
        bus.fifo_row  = row_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = CLEAR;
                    row_d   = '0;
                    sc_d    = '0;
                end
            end
            CLEAR: begin
                bus.mac_clr = 1'b1;
                state_d     = LOAD_REQ;
            end
            LOAD_REQ: begin
                bus.mem_rd_en = 1'b1;
                state_d       = LOAD_WAIT;
            end
            LOAD_WAIT: begin
                if (bus.mem_rvalid) begin
                    if (row_last) begin
                        state_d = SHIFT;
                    end else begin
                        row_d   = row_q + ROW_W'(1);
                        state_d = LOAD_REQ;
                    end
                end
            end
            SHIFT: begin
                bus.fifo_en = 1'b1;
                if (sc_last) begin
                    state_d = DONE;
                end else begin
                    sc_d = sc_q + SC_W'(1);
                end
            end
            DONE: begin
                bus.done = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Abort cancels the pass; counters hold so a colliding rvalid has no effect.
        if (state_q != IDLE && bus.abort) begin
            state_d = IDLE;
            row_d   = row_q;
            sc_d    = sc_q;
        end
    end
endmodule

// File: tb/tb_systolic_load_ctrl.sv
// Cycle-accurate scoreboard bench for systolic_load_ctrl with a latency-programmable row memory.
module tb_systolic_load_ctrl;
    localparam int unsigned DEPTH     = 8;
    localparam int unsigned ROW_W     = 3;
    localparam int unsigned SHIFT_LEN = 22;
    localparam int          BIG       = 32'h7fff_ffff;

    typedef struct {
        int               cyc;
        logic [5:0]       ctl;   // {rd_en, fifo_wr, fifo_en, mac_clr, busy, done}
        logic             chk;
        logic [ROW_W-1:0] addr;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   lat_cfg [DEPTH];
    logic resp_rvalid;
    logic spur_rvalid;
    bit   pend = 1'b0;
    int   pend_at = 0;
    exp_t sb[$];

    systolic_load_ctrl_if #(.ROW_W(ROW_W)) bus ();

    systolic_load_ctrl #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    assign bus.mem_rvalid = resp_rvalid | spur_rvalid;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Row memory: answers each read lat_cfg[row] cycles after the request.
    initial begin
        resp_rvalid = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pend = 1'b0;
            end else if (bus.mem_rd_en) begin
                pend    = 1'b1;
                pend_at = cyc + lat_cfg[bus.mem_addr];
            end
            @(posedge clk);
            #1;
            resp_rvalid = pend && (cyc == pend_at);
            if (resp_rvalid) pend = 1'b0;
        end
    end

    function automatic logic [5:0] obs();
        return {bus.mem_rd_en, bus.fifo_wr, bus.fifo_en, bus.mac_clr, bus.busy, bus.done};
    endfunction

    task automatic push(input int stop, input int c, input logic [5:0] ctl, input logic chk, input int a);
        exp_t e;
        if (c < stop) begin
            e.cyc  = c;
            e.ctl  = ctl;
            e.chk  = chk;
            e.addr = ROW_W'(a);
            sb.push_back(e);
        end
    endtask

    // Expected per-cycle outputs of a pass whose start is sampled at the end of cycle t0.
    task automatic gen(input int t0, input int stop);
        int c;
        c = t0 + 1;
        push(stop, c, 6'b000110, 1'b1, 0);
        c++;
        for (int r = 0; r < DEPTH; r++) begin
            push(stop, c, 6'b100010, 1'b1, r);
            c++;
            for (int w = 1; w <= lat_cfg[r]; w++) begin
                push(stop, c, {1'b0, (w == lat_cfg[r]), 4'b0010}, 1'b1, r);
                c++;
            end
        end
        for (int s = 0; s < SHIFT_LEN; s++) begin
            push(stop, c, 6'b001010, 1'b1, DEPTH - 1);
            c++;
        end
        push(stop, c, 6'b000011, 1'b1, DEPTH - 1);
        c++;
        push(stop, c, 6'b000000, 1'b0, 0);
    endtask

    task automatic check_cycle();
        exp_t e;
        if (sb.size() != 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            total++;
            assert (e.cyc == cyc && obs() === e.ctl) else begin
                bad++;
                $error("FAIL ctl cyc=%0d exp_cyc=%0d got=%b want=%b", cyc, e.cyc, obs(), e.ctl);
            end
            if (e.chk) begin
                total++;
                assert (bus.mem_addr === e.addr && bus.fifo_row === e.addr) else begin
                    bad++;
                    $error("FAIL addr cyc=%0d got=%0d/%0d want=%0d", cyc, bus.mem_addr, bus.fifo_row, e.addr);
                end
            end
        end
    endtask

    task automatic next();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        total++;
        assert (obs() === 6'b0 && bus.mem_addr === '0 && bus.fifo_row === '0) else begin
            bad++;
            $error("FAIL %s got=%b addr=%0d want=000000 addr=0", tag, obs(), bus.mem_addr);
        end
    endtask

    task automatic check_drained(input string tag);
        total++;
        assert (sb.size() == 0) else begin
            bad++;
            $error("FAIL %s got=%0d pending want=0", tag, sb.size());
        end
        sb.delete();
    endtask

    task automatic drive_pass(input int n, input int abort_at, input bit spurious);
        for (int r = 0; r < n; r++) begin
            bus.start   = (r == 0) || (spurious && (r == 10 || r == 25));
            spur_rvalid = spurious && (r == 1 || r == 20);
            bus.abort   = (r == abort_at);
            next();
        end
        bus.start   = 1'b0;
        bus.abort   = 1'b0;
        spur_rvalid = 1'b0;
    endtask

    initial begin
        int t0;
        rst_n       = 1'b0;
        bus.start   = 1'b0;
        bus.abort   = 1'b0;
        spur_rvalid = 1'b0;
        for (int i = 0; i < DEPTH; i++) lat_cfg[i] = 1;

        // Reset state
        repeat (3) next();
        check_zero("reset_low");
        rst_n = 1'b1;
        next();
        check_zero("reset_released");

        // Basic pass, L=1
        t0 = cyc;
        gen(t0, BIG);
        drive_pass(42, -1, 1'b0);
        check_drained("basic_pass");

        // Row 3 answered after 5 cycles
        lat_cfg[3] = 5;
        t0 = cyc;
        gen(t0, BIG);
        drive_pass(46, -1, 1'b0);
        check_drained("slow_row3");
        lat_cfg[3] = 1;

        // Spurious start and rvalid
        t0 = cyc;
        gen(t0, BIG);
        drive_pass(42, -1, 1'b1);
        check_drained("spurious");

        // Abort in SHIFT, then restart right away
        t0 = cyc;
        gen(t0, t0 + 21);
        push(BIG, t0 + 21, 6'b000000, 1'b0, 0);
        push(BIG, t0 + 22, 6'b000000, 1'b0, 0);
        drive_pass(22, 20, 1'b0);
        t0 = cyc;
        gen(t0, BIG);
        drive_pass(42, -1, 1'b0);
        check_drained("abort_shift_restart");

        // Abort colliding with rvalid for row 2
        t0 = cyc;
        gen(t0, t0 + 7);
        push(BIG, t0 + 7, 6'b000010, 1'b1, 2);
        push(BIG, t0 + 8, 6'b000000, 1'b0, 0);
        drive_pass(9, 7, 1'b0);
        check_drained("abort_vs_rvalid");
        repeat (3) next();

        // Async reset in LOAD_WAIT for row 5
        t0 = cyc;
        gen(t0, t0 + 13);
        push(BIG, t0 + 13, 6'b000000, 1'b1, 0);
        drive_pass(13, -1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("async_reset");
        next();
        next();
        rst_n = 1'b1;
        next();
        check_drained("reset_midpass");
        t0 = cyc;
        gen(t0, BIG);
        drive_pass(42, -1, 1'b0);
        check_drained("after_reset_pass");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
